// File: rtl/dac_tx.sv
// Serial DAC transmitter: converts signed 20-bit samples to 12-bit offset binary
// and shifts 16-bit frames MSB-first to a DAC121S101-style DAC. Optional macro: DAC_SAT_EN.
module dac_tx #(
    parameter int         CLK_DIV = 2,
    parameter int         GAP_CYC = 4,
    parameter logic [1:0] PD_MODE = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic        cs,
    output logic        sclk,
    output logic        sdata,
    output logic        busy,
    output logic        done,
    output logic        sat
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC - 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sclk_hi;
    logic [15:0]        shift_reg;
    logic [11:0]        clip12;
    logic               clip_sat;
    logic [15:0]        frame;
    logic               div_last;
    logic               gap_last;

`ifdef DAC_SAT_EN
    always_comb begin
        clip12   = din[11:0];
        clip_sat = 1'b0;
        if ($signed(din) > 20'sd2047) begin
            clip12   = 12'h7FF;
            clip_sat = 1'b1;
        end else if ($signed(din) < -20'sd2048) begin
            clip12   = 12'h800;
            clip_sat = 1'b1;
        end
    end
`else
    logic din_hi_unused;
    assign din_hi_unused = ^din[19:12];
    assign clip12        = din[11:0];
    assign clip_sat      = 1'b0;
`endif

    assign frame    = {2'b00, PD_MODE, clip12 ^ 12'h800};
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
    // The IDLE accept cycle is the last cs-high cycle, so GAP itself lasts GAP_CYC-1 cycles.
    assign gap_last = (gap_cnt == GAP_W'(GAP_CYC - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        busy      = 1'b1;
        cs        = 1'b0;
        sclk      = 1'b1;
        sdata     = shift_reg[15];
        case (state)
            IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
                cs        = 1'b1;
                sdata     = 1'b0;
                if (din_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sclk = sclk_hi;
                if (div_last && sclk_hi && (bit_cnt == 4'd0)) begin
                    if (GAP_CYC > 1) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                cs    = 1'b1;
                sdata = 1'b0;
                if (gap_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data advances on the clk edge that raises sclk, so the DAC sees stable data at the fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            bit_cnt   <= 4'd15;
            gap_cnt   <= '0;
            sclk_hi   <= 1'b0;
            shift_reg <= '0;
            sat       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state != IDLE) && (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        shift_reg <= frame;
                        sat       <= clip_sat;
                        div_cnt   <= '0;
                    end
                end
                SETUP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_hi <= 1'b0;
                        bit_cnt <= 4'd15;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sclk_hi <= !sclk_hi;
                        if (!sclk_hi) begin
                            shift_reg <= {shift_reg[14:0], 1'b0};
                        end else if (bit_cnt == 4'd0) begin
                            gap_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt - 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (!gap_last) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
